dsp_mult_acc: RTL and testbench
===============================

DSP_MULT_ACC -- requirements
Module: dsp_mult_acc

Interface
REQ-001 The block SHALL have parameter MREG, default 1, meaning 1 = multiplier output registered and 0 = multiplier stage bypassed combinationally.
REQ-002 The block SHALL have parameter WIDTH_IN, default 18, giving the width of signed operands a, b and d.
REQ-003 The block SHALL have parameter WIDTH_ACC, default 48, giving the width of c and p.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-006 The block SHALL have port ce, input, 1 bit: clock enable for every register in the block.
REQ-007 The block SHALL have port in_valid, input, 1 bit: marks a, b, d, c, opmode and carry_in as valid this cycle.
REQ-008 The block SHALL have port a, input, WIDTH_IN bits: signed multiplier operand, fed by the upstream operand register/bypass stage.
REQ-009 The block SHALL have port b, input, WIDTH_IN bits: signed pre-adder operand.
REQ-010 The block SHALL have port d, input, WIDTH_IN bits: signed pre-adder operand.
REQ-011 The block SHALL have port c, input, WIDTH_ACC bits: post-adder load operand.
REQ-012 The block SHALL have port opmode, input, 4 bits: bit0 pre-adder enable, bit1 pre-subtract, bit2 accumulate, bit3 post-subtract.
REQ-013 The block SHALL have port carry_in, input, 1 bit: carry into the post-adder.
REQ-014 The block SHALL have port p, output, WIDTH_ACC bits: accumulator register.
REQ-015 The block SHALL have port carry_out, output, 1 bit: registered carry out of the post-adder MSB.
REQ-016 The block SHALL have port out_valid, output, 1 bit: p updated by a valid op this cycle.
REQ-017 The block SHALL have port ovf, output, 1 bit: sticky signed-overflow flag.

Function
REQ-018 Stage 1 (registered) SHALL compute the pre-adder result, sign-extended to WIDTH_IN+1 bits: b+d when opmode[1:0]=01, b-d when 11, b when bit0=0; it SHALL also register a, c, opmode, carry_in and in_valid.
REQ-019 Stage 2 SHALL form the full-precision signed product of stage-1 a and stage-1 pre-adder result (2*WIDTH_IN+1 bits), registered when MREG=1 and passed combinationally when MREG=0.
REQ-020 Stage 3 (registered) SHALL compute p <= Z + X + carry_in, with X = the sign-extended product, or its two's complement when opmode[3]=1; Z = current p when opmode[2]=1, else c.
REQ-021 Latency from in_valid to out_valid SHALL be 3 ce-qualified cycles when MREG=1 and 2 when MREG=0.
REQ-022 When ce=0, all registers SHALL hold and out_valid SHALL hold its value; the latency count SHALL advance only on cycles with ce=1.
REQ-023 A stage carrying in_valid=0 SHALL leave p, carry_out and ovf unchanged, and SHALL drive out_valid to 0 when it reaches stage 3.
REQ-024 carry_out SHALL be bit WIDTH_ACC of the unsigned (WIDTH_ACC+1)-bit sum; p SHALL wrap modulo 2^WIDTH_ACC and SHALL NOT saturate.
REQ-025 ovf SHALL be set when the signed sum's operand signs match and the result sign differs.
REQ-026 ovf SHALL be cleared by any valid stage-3 op with opmode[2]=0 (load) that does not itself overflow.
REQ-027 Back-to-back accumulate ops SHALL each see the p produced by the immediately preceding valid op, with no bubbles.
REQ-028 The most negative a times the most negative pre-adder result SHALL produce the exact positive product, with no truncation.

Reset
REQ-029 rst=0 SHALL asynchronously clear every pipeline register, p, carry_out, out_valid and ovf to 0, independent of ce and clk.
REQ-030 rst deassertion SHALL take effect on the next rising clk; ops in flight at assertion SHALL be discarded, with no out_valid for them.

Verification
REQ-031 The bench SHALL cover load: a=3, b=4, d=5, opmode=0001, c=10, carry_in=0, MREG=1 -> p=37 and out_valid=1 exactly 3 cycles later, ovf=0.
REQ-032 The bench SHALL cover accumulate: four consecutive valid ops a=2, b=1, opmode=0100 following a load of c=0 -> p = 2, 4, 6, 8 on four consecutive cycles.
REQ-033 The bench SHALL cover overflow: load c=0x7FFF_FFFF_FFFF with a=1, b=1, opmode=0000 -> p=0x8000_0000_0000 and ovf=1; a following load with c=0, a=0 -> ovf=0.
REQ-034 The bench SHALL cover ce stall: hold ce=0 for 5 cycles mid-pipeline -> p and out_valid frozen, and the result appears 3 ce-high cycles after issue.
REQ-035 The bench SHALL cover async reset: pull rst low between clk edges with 2 ops in flight -> p=0 and out_valid=0 immediately, and no out_valid after release.
REQ-036 The bench SHALL cover subtract and corner cases: a=-131072, b=-131072, opmode=1000, c=0 -> p = -2^34 (sign-extended), carry_out = unsigned carry; repeat with MREG=0 -> latency 2.

Source files
------------

// File: rtl/dsp_mult_acc.sv
// -----------------------------------------------------------------------------
// dsp_mult_acc
//   Pipelined pre-adder / multiplier / post-adder accumulator slice.
//   Stage 1 registers the operands and the pre-adder result (b, b+d or b-d).
//   Stage 2 forms the full-precision signed product. It is registered when
//   MREG=1 and combinational when MREG=0.
//   Stage 3 adds the product, or its negation, to either c or the current p.
//   It also adds carry_in and registers p, carry_out and a sticky ovf flag.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset, clears every register
//   ce         clock enable for every register
//   in_valid   a, b, d, c, opmode and carry_in are valid this cycle
//   a          signed multiplier operand        [WIDTH_IN-1:0]
//   b, d       signed pre-adder operands        [WIDTH_IN-1:0]
//   c          post-adder load operand          [WIDTH_ACC-1:0]
//   opmode     0: pre-add enable, 1: pre-subtract, 2: accumulate,
//              3: post-subtract
//   carry_in   carry into the post-adder
//   p          accumulator register             [WIDTH_ACC-1:0]
//   carry_out  registered carry out of the post-adder MSB
//   out_valid  p was updated by a valid op on the last enabled edge
//   ovf        sticky signed-overflow flag
// -----------------------------------------------------------------------------
module dsp_mult_acc #(
  parameter int MREG      = 1,
  parameter int WIDTH_IN  = 18,
  parameter int WIDTH_ACC = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [WIDTH_IN-1:0]  a,
  input  logic [WIDTH_IN-1:0]  b,
  input  logic [WIDTH_IN-1:0]  d,
  input  logic [WIDTH_ACC-1:0] c,
  input  logic [3:0]           opmode,
  input  logic                 carry_in,
  output logic [WIDTH_ACC-1:0] p,
  output logic                 carry_out,
  output logic                 out_valid,
  output logic                 ovf
);

  localparam int PRE_W  = WIDTH_IN + 1;
  localparam int PROD_W = 2 * WIDTH_IN + 1;

  // Pre-adder: the result is one bit wider so b+d and b-d never wrap.
  function automatic logic signed [PRE_W-1:0] pre_add(
    input logic signed [WIDTH_IN-1:0] bv,
    input logic signed [WIDTH_IN-1:0] dv,
    input logic [1:0]                 mode
  );
    logic signed [PRE_W-1:0] bx;
    logic signed [PRE_W-1:0] dx;
    logic signed [PRE_W-1:0] res;
    bx  = {bv[WIDTH_IN-1], bv};
    dx  = {dv[WIDTH_IN-1], dv};
    res = bx;
    if (mode[0]) res = mode[1] ? (bx - dx) : (bx + dx);
    return res;
  endfunction

  // Two's-complement overflow: the addends agree in sign but the sum does not.
  function automatic logic signed_ovf(
    input logic z_msb,
    input logic x_msb,
    input logic s_msb
  );
    return (z_msb == x_msb) && (s_msb != z_msb);
  endfunction

  logic signed [WIDTH_IN-1:0]  a_p1;
  logic signed [PRE_W-1:0]     pre_p1;
  logic        [WIDTH_ACC-1:0] c_p1;
  logic        [1:0]           mode_p1;   // {post-subtract, accumulate}
  logic                        cin_p1;
  logic                        vld_p1;

  logic signed [PROD_W-1:0]    a_x;
  logic signed [PROD_W-1:0]    pre_x;
  logic signed [PROD_W-1:0]    mult_out;

  logic signed [PROD_W-1:0]    prod_p2;
  logic        [WIDTH_ACC-1:0] c_p2;
  logic        [1:0]           mode_p2;
  logic                        cin_p2;
  logic                        vld_p2;

  logic        [WIDTH_ACC-1:0] x_ext;
  logic        [WIDTH_ACC-1:0] x_s3;
  logic        [WIDTH_ACC-1:0] z_s3;
  logic        [WIDTH_ACC:0]   sum_s3;
  logic                        ovf_s3;

  // ---- stage 1: operand capture and pre-adder ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_p1    <= '0;
      pre_p1  <= '0;
      c_p1    <= '0;
      mode_p1 <= '0;
      cin_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (ce) begin
      a_p1    <= a;
      pre_p1  <= pre_add(b, d, opmode[1:0]);
      c_p1    <= c;
      mode_p1 <= opmode[3:2];
      cin_p1  <= carry_in;
      vld_p1  <= in_valid;
    end
  end

  // ---- stage 2: full-precision multiply ----
  // Both factors are widened to the product width first. The product of the
  // two most negative values then comes out exact and positive.
  assign a_x      = {{(PROD_W-WIDTH_IN){a_p1[WIDTH_IN-1]}}, a_p1};
  assign pre_x    = {{(PROD_W-PRE_W){pre_p1[PRE_W-1]}}, pre_p1};
  assign mult_out = a_x * pre_x;

  generate
    if (MREG != 0) begin : g_mreg
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          prod_p2 <= '0;
          c_p2    <= '0;
          mode_p2 <= '0;
          cin_p2  <= 1'b0;
          vld_p2  <= 1'b0;
        end else if (ce) begin
          prod_p2 <= mult_out;
          c_p2    <= c_p1;
          mode_p2 <= mode_p1;
          cin_p2  <= cin_p1;
          vld_p2  <= vld_p1;
        end
      end
    end else begin : g_mbypass
      assign prod_p2 = mult_out;
      assign c_p2    = c_p1;
      assign mode_p2 = mode_p1;
      assign cin_p2  = cin_p1;
      assign vld_p2  = vld_p1;
    end
  endgenerate

  // ---- stage 3: post-adder / accumulator ----
  // The sum is formed one bit wider, unsigned, so its top bit is the carry out.
  assign x_ext  = {{(WIDTH_ACC-PROD_W){prod_p2[PROD_W-1]}}, prod_p2};
  assign x_s3   = mode_p2[1] ? -x_ext : x_ext;
  assign z_s3   = mode_p2[0] ? p : c_p2;
  assign sum_s3 = {1'b0, z_s3} + {1'b0, x_s3} + {{WIDTH_ACC{1'b0}}, cin_p2};
  assign ovf_s3 = signed_ovf(z_s3[WIDTH_ACC-1], x_s3[WIDTH_ACC-1],
                             sum_s3[WIDTH_ACC-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p         <= '0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= vld_p2;
      if (vld_p2) begin
        p         <= sum_s3[WIDTH_ACC-1:0];
        carry_out <= sum_s3[WIDTH_ACC];
        // ovf is sticky: an overflow sets it, and only a clean load clears it.
        if (ovf_s3)           ovf <= 1'b1;
        else if (!mode_p2[0]) ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mult_acc.sv
// -----------------------------------------------------------------------------
// tb_dsp_mult_acc
//   Drives one MREG=1 and one MREG=0 instance from the same stimulus.
//   The reference model works out each op's result from plain integer
//   arithmetic when the op is issued. Ops complete in order, so an accumulate
//   always sees the previous valid op's result. The model then delays that
//   result by each instance's latency, counted in ce-qualified cycles.
// -----------------------------------------------------------------------------
module tb_dsp_mult_acc;

  localparam int WI = 18;
  localparam int WA = 48;
  localparam longint MASK = (longint'(1) << WA) - 1;
  localparam longint MAXS = (longint'(1) << (WA - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (WA - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          in_valid;
  logic [WI-1:0] a, b, d;
  logic [WA-1:0] c;
  logic [3:0]    opmode;
  logic          carry_in;

  logic [WA-1:0] p1, p0;
  logic          co1, co0, ov1, ov0, vl1, vl0;

  always #5 clk = ~clk;

  dsp_mult_acc #(.MREG(1), .WIDTH_IN(WI), .WIDTH_ACC(WA)) dut_m1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .opmode(opmode), .carry_in(carry_in),
    .p(p1), .carry_out(co1), .out_valid(vl1), .ovf(ov1)
  );

  dsp_mult_acc #(.MREG(0), .WIDTH_IN(WI), .WIDTH_ACC(WA)) dut_m0 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .opmode(opmode), .carry_in(carry_in),
    .p(p0), .carry_out(co0), .out_valid(vl0), .ovf(ov0)
  );

  typedef struct packed {
    logic          v;
    logic [WA-1:0] p;
    logic          co;
    logic          ov;
  } ent_t;

  ent_t   line1 [2];   // MREG=1: result shows 3 enabled edges after issue
  ent_t   line0;       // MREG=0: result shows 2 enabled edges after issue
  ent_t   vis1, vis0;  // expected visible outputs
  longint acc_m;       // result of the most recent valid op
  logic   ovf_m;
  int     vectors     = 0;
  int     miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    line1[0] = '0; line1[1] = '0; line0 = '0;
    vis1 = '0; vis0 = '0;
    acc_m = 0; ovf_m = 1'b0;
  endtask

  task automatic show(inout ent_t vis, input ent_t e);
    vis.v = e.v;
    if (e.v) begin
      vis.p = e.p; vis.co = e.co; vis.ov = e.ov;
    end
  endtask

  task automatic model_edge();
    ent_t   n, out;
    longint aa, bb, dd, pre, prod, x, z, s, tot;
    n = '0;
    if (!rst) begin
      model_reset();
    end else if (ce) begin
      if (in_valid) begin
        aa = longint'($signed(a));
        bb = longint'($signed(b));
        dd = longint'($signed(d));
        if (opmode[0]) pre = opmode[1] ? (bb - dd) : (bb + dd);
        else           pre = bb;
        prod = aa * pre;
        x    = opmode[3] ? -prod : prod;
        z    = opmode[2] ? acc_m : longint'($signed(c));
        s    = z + x + longint'(carry_in);
        tot  = (z & MASK) + (x & MASK) + longint'(carry_in);
        if (s > MAXS || s < MINS) ovf_m = 1'b1;
        else if (!opmode[2])      ovf_m = 1'b0;
        n.v  = 1'b1;
        n.p  = tot[WA-1:0];
        n.co = ((tot >> WA) != 0);
        n.ov = ovf_m;
        acc_m = longint'($signed(n.p));
      end
      out = line1[1]; line1[1] = line1[0]; line1[0] = n;
      show(vis1, out);
      out = line0; line0 = n;
      show(vis0, out);
    end
  endtask

  task automatic check_all();
    check("m1_p", p1, vis1.p);   check("m1_vld", vl1, vis1.v);
    check("m1_co", co1, vis1.co); check("m1_ovf", ov1, vis1.ov);
    check("m0_p", p0, vis0.p);   check("m0_vld", vl0, vis0.v);
    check("m0_co", co0, vis0.co); check("m0_ovf", ov0, vis0.ov);
  endtask

  // One clock: model follows the edge, outputs are checked 2 time units later,
  // and the task returns on the falling edge, where new inputs are driven.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #2;
    check_all();
    @(negedge clk);
  endtask

  task automatic op(input logic [WI-1:0] ta, input logic [WI-1:0] tb,
                    input logic [WI-1:0] td, input logic [WA-1:0] tc,
                    input logic [3:0] tm, input logic tcin);
    in_valid = 1'b1; a = ta; b = tb; d = td; c = tc; opmode = tm; carry_in = tcin;
  endtask

  task automatic idle();
    in_valid = 1'b0; a = '0; b = '0; d = '0; c = '0; opmode = '0; carry_in = 1'b0;
  endtask

  initial begin
    logic [63:0] r64;
    rst = 1'b0; ce = 1'b1;
    idle();
    model_reset();
    cyc(); cyc();
    check("rst_p", p1, 0); check("rst_vld", vl1, 0); check("rst_ovf", ov1, 0);
    rst = 1'b1;
    cyc();

    // load with pre-add: 3*(4+5)+10 = 37
    op(3, 4, 5, 10, 4'b0001, 1'b0); cyc();
    idle(); cyc();
    check("load_m0_vld", vl0, 1); check("load_m0_p", p0, 37); check("load_m1_early", vl1, 0);
    cyc();
    check("load_m1_vld", vl1, 1); check("load_m1_p", p1, 37); check("load_m1_ovf", ov1, 0);
    cyc();
    check("load_m1_vld_drop", vl1, 0);

    // load 0, then four back-to-back accumulates of 2*1
    op(0, 0, 0, 0, 4'b0000, 1'b0); cyc();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) op(2, 1, 0, 0, 4'b0100, 1'b0);
      else       idle();
      cyc();
      if (i >= 1) begin
        check("acc_seq_p", p1, WA'(2 * (i - 1)));
        check("acc_seq_vld", vl1, 1);
      end
    end

    // signed overflow on load, then cleared by a clean load
    op(1, 1, 0, 48'h7FFF_FFFF_FFFF, 4'b0000, 1'b0); cyc();
    idle(); cyc(); cyc();
    check("ovf_p", p1, 48'h8000_0000_0000); check("ovf_set", ov1, 1);
    op(0, 0, 0, 0, 4'b0000, 1'b0); cyc();
    idle(); cyc(); cyc();
    check("ovf_clr_p", p1, 0); check("ovf_clr", ov1, 0);

    // ce stall with two ops in flight
    op(5, 6, 0, 1, 4'b0000, 1'b0); cyc();
    op(2, 3, 0, 100, 4'b0000, 1'b0); cyc();
    idle(); cyc();
    check("stall_pre_p", p1, 31); check("stall_pre_vld", vl1, 1);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_hold_p", p1, 31); check("stall_hold_vld", vl1, 1);
    end
    ce = 1'b1; cyc();
    check("stall_done_p", p1, 106); check("stall_done_vld", vl1, 1);
    cyc();

    // asynchronous reset between edges with two ops in flight
    op(7, 1, 0, 0, 4'b0000, 1'b0); cyc();
    op(9, 1, 0, 0, 4'b0100, 1'b0); cyc();
    idle();
    #1 rst = 1'b0;
    #1 model_reset();
    check("arst_m1_p", p1, 0); check("arst_m1_vld", vl1, 0);
    check("arst_m0_p", p0, 0); check("arst_m0_vld", vl0, 0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("arst_no_vld_m1", vl1, 0); check("arst_no_vld_m0", vl0, 0);
    end

    // post-subtract of the most negative product
    op(18'h20000, 18'h20000, 0, 0, 4'b1000, 1'b0); cyc();
    idle(); cyc();
    check("sub_m0_vld", vl0, 1); check("sub_m0_p", p0, 48'hFFFC_0000_0000);
    check("sub_m0_co", co0, 0); check("sub_m1_early", vl1, 0);
    cyc();
    check("sub_m1_vld", vl1, 1); check("sub_m1_p", p1, 48'hFFFC_0000_0000);
    check("sub_m1_co", co1, 0);

    // carry out of the MSB, then the largest product with carry_in
    op(18'h20000, 18'h20000, 0, 48'h0004_0000_0000, 4'b1000, 1'b0); cyc();
    op(18'h20000, 18'h20000, 18'h20000, 0, 4'b0001, 1'b1); cyc();
    idle(); cyc();
    check("carry_p", p1, 0); check("carry_co", co1, 1); check("carry_ovf", ov1, 0);
    cyc();
    check("maxprod_p", p1, 48'h0008_0000_0001); check("maxprod_co", co1, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      ce       = ($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      a        = ($urandom_range(0, 9) == 0) ? 18'h20000 : WI'($urandom);
      b        = WI'($urandom);
      d        = WI'($urandom);
      r64      = {$urandom, $urandom};
      c        = ($urandom_range(0, 3) == 0) ? WA'($urandom_range(0, 1000)) : r64[WA-1:0];
      opmode   = 4'($urandom);
      carry_in = 1'($urandom);
      cyc();
    end
    idle(); ce = 1'b1;
    cyc(); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
